// File: rtl/a2d_scanner.sv
// Round-robin SPI scanner for the ADC128S pot converter. Each channel is one
// command frame plus one read frame; results land in per-channel pot registers.
module a2d_scanner #(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned SCLK_DIV = 32,
    parameter int unsigned SMOOTH   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cont,
    output logic                 SS_n,
    output logic                 SCLK,
    output logic                 MOSI,
    input  logic                 MISO,
    output logic [NUM_CH*12-1:0] pots,
    output logic                 smpl_vld,
    output logic [2:0]           smpl_ch,
    output logic                 pass_done,
    output logic                 busy
);
    localparam int unsigned DW   = 12;
    localparam int unsigned CH_W = 3;
    localparam int unsigned HALF = SCLK_DIV / 2;
    localparam int unsigned PH_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned HC_W = 6;
    localparam int unsigned TX_W = 16;

    // Frames span 34 half-periods (lead, 16 bit periods, tail); gaps span 2.
    localparam logic [HC_W-1:0] FRAME_LAST    = HC_W'(33);
    localparam logic [HC_W-1:0] GAP_LAST      = HC_W'(1);
    localparam logic [HC_W-1:0] LAST_BIT_HALF = HC_W'(31);
    localparam logic [PH_W-1:0] PH_LAST       = PH_W'(HALF - 1);
    localparam logic [CH_W-1:0] LAST_CH       = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, CMD, GAP1, RD, GAP2} state_t;

    state_t            state, state_nxt;
    logic [PH_W-1:0]   ph, ph_nxt;
    logic [HC_W-1:0]   hc, hc_nxt;
    logic [CH_W-1:0]   ch, ch_nxt;
    logic [TX_W-1:0]   tx_sr, tx_nxt;
    logic [DW-1:0]     rx_sr, rx_nxt;
    logic [NUM_CH-1:0] first;

    logic ph_last, last, in_frame, frame_nxt;
    logic ss_n_nxt, sclk_nxt, mosi_nxt, busy_nxt, vld_nxt, pd_nxt;

    logic [DW-1:0]        cur_pot, new_pot;
    logic                 first_sel;
    logic signed [DW:0]   diff;

    // Sequencer: half-period counters drive SCLK, shifts and state changes.
    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        hc_nxt    = hc;
        ch_nxt    = ch;
        tx_nxt    = tx_sr;
        rx_nxt    = rx_sr;
        busy_nxt  = busy;
        vld_nxt   = 1'b0;
        pd_nxt    = 1'b0;

        in_frame = (state == CMD) || (state == RD);
        ph_last  = (ph == PH_LAST);
        last     = ph_last && (hc == (in_frame ? FRAME_LAST : GAP_LAST));

        if (state != IDLE) begin
            if (ph_last) begin
                ph_nxt = '0;
                hc_nxt = hc + HC_W'(1);
            end else begin
                ph_nxt = ph + PH_W'(1);
            end
        end

        // Even half ending -> SCLK falls (next MOSI bit); odd -> SCLK rises (sample MISO).
        if (in_frame && ph_last && (hc <= LAST_BIT_HALF)) begin
            if (hc[0]) rx_nxt = {rx_sr[DW-2:0], MISO};
            else       tx_nxt = {tx_sr[TX_W-2:0], 1'b0};
        end

        case (state)
            IDLE: begin
                if (start || cont) begin
                    state_nxt = CMD;
                    ch_nxt    = '0;
                    busy_nxt  = 1'b1;
                    tx_nxt    = {2'b00, CH_W'(0), 11'b0};
                end
            end
            CMD: begin
                if (last) state_nxt = GAP1;
            end
            GAP1: begin
                if (last) begin
                    state_nxt = RD;
                    tx_nxt    = '0;
                end
            end
            RD: begin
                if (last) state_nxt = GAP2;
            end
            GAP2: begin
                if ((ph == '0) && (hc == '0)) begin
                    vld_nxt = 1'b1;
                    pd_nxt  = (ch == LAST_CH);
                end
                if (last) begin
                    if (ch != LAST_CH) begin
                        state_nxt = CMD;
                        ch_nxt    = ch + CH_W'(1);
                        tx_nxt    = {2'b00, ch + CH_W'(1), 11'b0};
                    end else if (cont) begin
                        state_nxt = CMD;
                        ch_nxt    = '0;
                        tx_nxt    = {2'b00, CH_W'(0), 11'b0};
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state) begin
            ph_nxt = '0;
            hc_nxt = '0;
        end

        frame_nxt = (state_nxt == CMD) || (state_nxt == RD);
        ss_n_nxt  = !frame_nxt;
        sclk_nxt  = !(frame_nxt && hc_nxt[0] && (hc_nxt < FRAME_LAST));
        mosi_nxt  = frame_nxt && tx_nxt[TX_W-1];
    end

    // Smoothing datapath for the channel being finished.
    always_comb begin
        cur_pot   = '0;
        first_sel = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (ch == CH_W'(i)) begin
                cur_pot   = pots[i*DW +: DW];
                first_sel = first[i];
            end
        end
        diff = $signed({1'b0, rx_sr}) - $signed({1'b0, cur_pot});
        if ((SMOOTH == 0) || first_sel) new_pot = rx_sr;
        else                            new_pot = cur_pot + DW'(diff >>> SMOOTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ph        <= '0;
            hc        <= '0;
            ch        <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            first     <= '1;
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
            MOSI      <= 1'b0;
            pots      <= '0;
            smpl_vld  <= 1'b0;
            smpl_ch   <= '0;
            pass_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ph        <= ph_nxt;
            hc        <= hc_nxt;
            ch        <= ch_nxt;
            tx_sr     <= tx_nxt;
            rx_sr     <= rx_nxt;
            SS_n      <= ss_n_nxt;
            SCLK      <= sclk_nxt;
            MOSI      <= mosi_nxt;
            smpl_vld  <= vld_nxt;
            pass_done <= pd_nxt;
            busy      <= busy_nxt;
            if (vld_nxt) begin
                smpl_ch <= ch;
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    if (ch == CH_W'(i)) begin
                        pots[i*DW +: DW] <= new_pot;
                        first[i]         <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_a2d_scanner.sv
// Bench for a2d_scanner: converter model on the SPI pins plus a scoreboard of
// expected pot updates, checked whenever smpl_vld pulses.
module tb_a2d_scanner;
    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned SCLK_DIV = 4;
    localparam int unsigned SMOOTH   = 2;
    localparam int FRAME  = 17 * SCLK_DIV;
    localparam int CH_CYC = 36 * SCLK_DIV;
    localparam int PASS   = NUM_CH * CH_CYC;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, cont = 1'b0, MISO = 1'b0;
    logic SS_n, SCLK, MOSI, smpl_vld, pass_done, busy;
    logic [2:0] smpl_ch;
    logic [NUM_CH*12-1:0] pots;

    always #5 clk = ~clk;

    a2d_scanner #(.NUM_CH(NUM_CH), .SCLK_DIV(SCLK_DIV), .SMOOTH(SMOOTH)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .pots(pots), .smpl_vld(smpl_vld), .smpl_ch(smpl_ch),
        .pass_done(pass_done), .busy(busy)
    );

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] pot;
        logic        pd;
    } exp_t;
    exp_t sbq[$];

    logic [11:0] mpot [NUM_CH];
    bit          mfirst [NUM_CH];

    function automatic logic [11:0] adc_data(input int p, input int c);
        if (c == 4) begin
            case (p % 3)
                0:       return 12'h800;
                1:       return 12'h000;
                default: return 12'hFFF;
            endcase
        end
        return 12'(c * 'h333 + 'h123 + p * 'h1F7);
    endfunction

    function automatic logic [11:0] smooth(input logic [11:0] p, input logic [11:0] s, input bit f);
        int d, q, den;
        if (f || SMOOTH == 0) return s;
        den = 1 << SMOOTH;
        d = int'(s) - int'(p);
        q = (d >= 0) ? d / den : -((-d + den - 1) / den);
        return 12'(int'(p) + q);
    endfunction

    function automatic logic [NUM_CH*12-1:0] model_pots();
        logic [NUM_CH*12-1:0] v;
        for (int i = 0; i < int'(NUM_CH); i++) v[i*12 +: 12] = mpot[i];
        return v;
    endfunction

    int cyc = 0, rst_edges = 0, frame_idx = 0, exp_ch = 0, pass_no = 0;
    int fall_cyc = 0, rise_cyc = 0, falls = 0, rises = 0, bitp = 0, last_vld = 0;
    int n_vld = 0, n_pd = 0;
    bit gap_ok = 0, have_prev = 0, idle_seen = 1;
    logic p_ss = 1'b1, p_sclk = 1'b1;
    logic [15:0] cmd = '0, tx = '0;
    logic [2:0]  cmd_ch = '0;

    // Converter model, frame-timing monitor and scoreboard consumer.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (SCLK !== p_sclk) rst_edges++;
            frame_idx = 0; exp_ch = 0; pass_no = 0; falls = 0; rises = 0;
            gap_ok = 0; have_prev = 0; idle_seen = 1; MISO = 1'b0;
            sbq.delete();
            for (int i = 0; i < int'(NUM_CH); i++) begin
                mpot[i] = '0;
                mfirst[i] = 1'b1;
            end
        end else begin
            if (!busy) begin
                idle_seen = 1;
                gap_ok = 0;
            end
            if (p_ss && !SS_n) begin
                if (gap_ok) check("gap_len", cyc - rise_cyc, SCLK_DIV);
                fall_cyc = cyc; falls = 0; rises = 0;
                cmd = '0;
                cmd[15] = MOSI;
                if (frame_idx % 2 == 0) begin
                    tx = 16'($urandom);
                end else begin
                    exp_t e;
                    logic [11:0] s;
                    tx = {4'($urandom), adc_data(pass_no, int'(cmd_ch))};
                    s = adc_data(pass_no, exp_ch);
                    mpot[exp_ch] = smooth(mpot[exp_ch], s, mfirst[exp_ch]);
                    mfirst[exp_ch] = 1'b0;
                    e.ch = 3'(exp_ch);
                    e.pot = mpot[exp_ch];
                    e.pd = (exp_ch == int'(NUM_CH) - 1);
                    sbq.push_back(e);
                end
                bitp = 15;
                MISO = tx[15];
            end else if (!SS_n) begin
                if (p_sclk && !SCLK) begin
                    falls++;
                    if (falls <= 15) cmd[15-falls] = MOSI;
                end
                if (!p_sclk && SCLK) begin
                    rises++;
                    bitp--;
                    if (bitp >= 0) MISO = tx[bitp];
                end
            end
            if (!p_ss && SS_n) begin
                check("ss_low_len", cyc - fall_cyc, FRAME);
                check("sclk_rises", rises, 16);
                if (frame_idx % 2 == 0) begin
                    check("cmd_word", cmd, {2'b00, 3'(exp_ch), 11'b0});
                    cmd_ch = cmd[13:11];
                end else begin
                    check("rd_word", cmd, 16'h0000);
                    if (exp_ch == int'(NUM_CH) - 1) pass_no++;
                    exp_ch = (exp_ch + 1) % int'(NUM_CH);
                end
                frame_idx++;
                rise_cyc = cyc;
                gap_ok = 1;
            end
            if (smpl_vld) begin
                n_vld++;
                check("vld_latency", cyc - rise_cyc, 1);
                if (have_prev && !idle_seen) check("vld_spacing", cyc - last_vld, CH_CYC);
                have_prev = 1; idle_seen = 0; last_vld = cyc;
                check("sb_nonempty", sbq.size() > 0, 1'b1);
                if (sbq.size() > 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("smpl_ch", smpl_ch, e.ch);
                    check("pot_value", pots[e.ch*12 +: 12], e.pot);
                    check("pass_done_flag", pass_done, e.pd);
                end
            end
            if (pass_done) n_pd++;
        end
        p_ss = SS_n;
        p_sclk = SCLK;
    end

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, busy, 1'b0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        int pd0, v0, n;
        #1 rst = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        check("rst_ss_n", SS_n, 1'b1);
        check("rst_sclk", SCLK, 1'b1);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_pots", pots, '0);
        check("rst_vld", smpl_vld, 1'b0);
        check("rst_smpl_ch", smpl_ch, 3'd0);
        check("rst_pass_done", pass_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sclk_edges", rst_edges, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single pass, with a stray start pulse partway through.
        pd0 = n_pd; v0 = n_vld;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("start_busy", busy, 1'b1);
        check("start_ss_n", SS_n, 1'b0);
        start = 1'b0;
        repeat (500) @(negedge clk);
        pulse_start();
        wait_idle(2 * PASS, "single");
        check("single_vld_count", n_vld - v0, NUM_CH);
        check("single_pd_count", n_pd - pd0, 1);
        check("single_pots_lo", pots[47:0], 48'hABC789456123);
        check("single_pots", pots, model_pots());
        repeat (200) @(negedge clk);
        check("no_extra_busy", busy, 1'b0);
        check("no_extra_ss_n", SS_n, 1'b1);

        // Continuous mode held for 2.5 passes.
        pd0 = n_pd;
        cont = 1'b1;
        repeat (5 * PASS / 2) @(negedge clk);
        cont = 1'b0;
        wait_idle(2 * PASS, "cont");
        check("cont_pd_count", n_pd - pd0, 3);
        check("cont_pot4", pots[59:48], 12'h85F);
        check("cont_pots", pots, model_pots());

        // Reset during bit 7 of channel 2's read frame.
        pulse_start();
        n = 0;
        while (!((frame_idx % 2 == 1) && (exp_ch == 2) && (falls == 9) && !SCLK) && n < 3 * PASS) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rd_bit7_reached", n < 3 * PASS, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_ss_n", SS_n, 1'b1);
        check("midrst_sclk", SCLK, 1'b1);
        check("midrst_pots", pots, '0);
        check("midrst_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        pulse_start();
        wait_idle(2 * PASS, "post_rst");
        check("post_rst_pot4_raw", pots[59:48], 12'h800);
        check("post_rst_pot0", pots[11:0], 12'h123);
        check("post_rst_pots", pots, model_pots());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
